// File: rtl/cpu3_pkg.sv
// Shared widths and fetch-line slot positions for the instruction front end.
package cpu3_pkg;

    localparam int INSTR_W   = 32;
    localparam int PC_W      = 14;
    localparam int LINE_W    = 64;

    localparam int SLOT0_MSB = 63;
    localparam int SLOT1_MSB = 31;

    // Number of valid slots in a fetch line, as an entry count.
    function automatic logic [1:0] slot_count(input logic [1:0] mask);
        return {1'b0, mask[0]} + {1'b0, mask[1]};
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side and decode-side signals of the instruction fetch queue.
interface inst_fetch_queue_if
    import cpu3_pkg::*;
#(
    parameter int PCW = PC_W
);
    logic                flush;
    logic                in_vld;
    logic [PCW-1:0]      in_pc;
    logic [LINE_W-1:0]   in_instr;
    logic [1:0]          in_mask;
    logic                in_rdy;
    logic [1:0]          out_vld;
    logic [INSTR_W-1:0]  out_instr0;
    logic [PCW-1:0]      out_pc0;
    logic [INSTR_W-1:0]  out_instr1;
    logic [PCW-1:0]      out_pc1;
    logic [1:0]          deq_cnt;
    logic [1:0]          err;

    // master: fetch/decode side driving the queue
    modport master (
        output flush, in_vld, in_pc, in_instr, in_mask, deq_cnt,
        input  in_rdy, out_vld, out_instr0, out_pc0, out_instr1, out_pc1, err
    );

    // slave: the queue itself
    modport slave (
        input  flush, in_vld, in_pc, in_instr, in_mask, deq_cnt,
        output in_rdy, out_vld, out_instr0, out_pc0, out_instr1, out_pc1, err
    );

endinterface

// File: rtl/inst_fetch_queue.sv
// Dual-enqueue / dual-dequeue circular instruction queue between fetch and decode.
module inst_fetch_queue
    import cpu3_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PCW   = PC_W
) (
    input  logic               clk,
    input  logic               rstn,
    inst_fetch_queue_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [PCW-1:0]     mem_pc    [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          rdy_q;
    logic [1:0]    err_q;

    logic          enq_ok;
    logic          deq_err;
    logic [1:0]    n_enq;
    logic [1:0]    n_deq;
    logic [CW-1:0] count_next;
    logic [CW-1:0] free_next;
    logic          rdy_next;
    logic [1:0]    err_next;

    logic          we_a;
    logic          we_b;
    logic [AW-1:0] wa_a;
    logic [AW-1:0] wa_b;
    logic [INSTR_W-1:0] wd_a;
    logic [INSTR_W-1:0] wd_b;
    logic [PCW-1:0]     pc_even;
    logic [PCW-1:0]     pc_odd;
    logic [AW-1:0]      rd_ptr1;

    assign pc_even = {bus.in_pc[PCW-1:1], 1'b0};
    assign pc_odd  = {bus.in_pc[PCW-1:1], 1'b1};

    always_comb begin
        enq_ok     = bus.in_vld & rdy_q & ~bus.flush;
        deq_err    = CW'(bus.deq_cnt) > count;
        n_enq      = enq_ok ? slot_count(bus.in_mask) : 2'd0;
        n_deq      = deq_err ? 2'd0 : bus.deq_cnt;
        count_next = count + CW'(n_enq) - CW'(n_deq);
        // Conservative: same-cycle dequeue is already in count_next, but not
        // the one decode may do next cycle.
        free_next  = CW'(DEPTH) - count_next;
        rdy_next   = free_next >= CW'(2);
        err_next   = err_q | {deq_err, bus.in_vld & ~rdy_q};
    end

    // Port a takes the first valid slot, port b the second (only with mask 11).
    always_comb begin
        we_a = enq_ok & (bus.in_mask != 2'b00);
        we_b = enq_ok & (bus.in_mask == 2'b11);
        wa_a = wr_ptr;
        wa_b = wr_ptr + AW'(1);
        wd_a = bus.in_mask[0] ? bus.in_instr[SLOT0_MSB -: INSTR_W]
                              : bus.in_instr[SLOT1_MSB -: INSTR_W];
        wd_b = bus.in_instr[SLOT1_MSB -: INSTR_W];
    end

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem_instr[wa_a] <= wd_a;
            mem_pc[wa_a]    <= bus.in_mask[0] ? pc_even : pc_odd;
        end
        if (we_b) begin
            mem_instr[wa_b] <= wd_b;
            mem_pc[wa_b]    <= pc_odd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_q  <= 1'b1;
            err_q  <= 2'b00;
        end else begin
            err_q <= err_next;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                rdy_q  <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr + AW'(n_enq);
                rd_ptr <= rd_ptr + AW'(n_deq);
                count  <= count_next;
                rdy_q  <= rdy_next;
            end
        end
    end

    assign rd_ptr1        = rd_ptr + AW'(1);
    assign bus.in_rdy     = rdy_q;
    assign bus.out_vld    = {count >= CW'(2), count >= CW'(1)};
    assign bus.out_instr0 = mem_instr[rd_ptr];
    assign bus.out_pc0    = mem_pc[rd_ptr];
    assign bus.out_instr1 = mem_instr[rd_ptr1];
    assign bus.out_pc1    = mem_pc[rd_ptr1];
    assign bus.err        = err_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with hand-computed expectations.
module tb_inst_fetch_queue;
    import cpu3_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    int   n_chk = 0;
    int   n_err = 0;

    inst_fetch_queue_if #(.PCW(14)) bus ();

    inst_fetch_queue #(.DEPTH(8), .PCW(14)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [13:0] pc, input logic [1:0] mask,
                         input logic [63:0] line, input logic [1:0] deq);
        bus.in_vld   = vld;
        bus.in_pc    = pc;
        bus.in_mask  = mask;
        bus.in_instr = line;
        bus.deq_cnt  = deq;
    endtask

    function automatic logic [31:0] tag_of(input logic [13:0] pc);
        return 32'hC0DE_0000 | {18'd0, pc};
    endfunction

    initial begin
        rstn = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 14'h0, 2'b00, 64'h0, 2'd0);
        step();
        step();
        chk("rst_vld", 64'(bus.out_vld), 64'd0);
        chk("rst_rdy", 64'(bus.in_rdy), 64'd1);
        chk("rst_err", 64'(bus.err), 64'd0);

        // Basic two-slot enqueue
        rstn = 1'b1;
        drive(1'b1, 14'h0004, 2'b11, 64'hAAAA0001_BBBB0002, 2'd0);
        step();
        drive(1'b0, 14'h0, 2'b00, 64'h0, 2'd0);
        chk("b_vld", 64'(bus.out_vld), 64'd3);
        chk("b_i0", 64'(bus.out_instr0), 64'hAAAA0001);
        chk("b_pc0", 64'(bus.out_pc0), 64'h0004);
        chk("b_i1", 64'(bus.out_instr1), 64'hBBBB0002);
        chk("b_pc1", 64'(bus.out_pc1), 64'h0005);
        chk("b_rdy", 64'(bus.in_rdy), 64'd1);

        // Single-slot lines
        drive(1'b0, 14'h0, 2'b00, 64'h0, 2'd2);
        step();
        chk("drain_vld", 64'(bus.out_vld), 64'd0);
        drive(1'b1, 14'h0007, 2'b10, 64'h11111111_22222222, 2'd0);
        step();
        chk("s1_vld", 64'(bus.out_vld), 64'd1);
        chk("s1_pc0", 64'(bus.out_pc0), 64'h0007);
        chk("s1_i0", 64'(bus.out_instr0), 64'h22222222);
        drive(1'b1, 14'h0010, 2'b01, 64'h33333333_44444444, 2'd1);
        step();
        chk("s0_vld", 64'(bus.out_vld), 64'd1);
        chk("s0_pc0", 64'(bus.out_pc0), 64'h0010);
        chk("s0_i0", 64'(bus.out_instr0), 64'h33333333);

        // Fill to full: rdy drops once fewer than two entries remain free
        drive(1'b0, 14'h0, 2'b00, 64'h0, 2'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 14'(14'h0020 + 2*i), 2'b11,
                  {tag_of(14'(14'h0020 + 2*i)), tag_of(14'(14'h0021 + 2*i))}, 2'd0);
            step();
            chk("fill_rdy", 64'(bus.in_rdy), (i < 3) ? 64'd1 : 64'd0);
        end
        chk("full_vld", 64'(bus.out_vld), 64'd3);
        drive(1'b1, 14'h0028, 2'b11, 64'hDEADDEAD_DEADDEAD, 2'd0);
        step();
        chk("ovf_err", 64'(bus.err), 64'd1);
        chk("ovf_pc0", 64'(bus.out_pc0), 64'h0020);
        chk("ovf_rdy", 64'(bus.in_rdy), 64'd0);
        drive(1'b0, 14'h0, 2'b00, 64'h0, 2'd2);
        step();
        chk("unfull_rdy", 64'(bus.in_rdy), 64'd1);
        chk("unfull_pc0", 64'(bus.out_pc0), 64'h0022);
        chk("unfull_pc1", 64'(bus.out_pc1), 64'h0023);
        chk("unfull_i0", 64'(bus.out_instr0), 64'(tag_of(14'h0022)));
        step();
        step();
        step();
        chk("empty_vld", 64'(bus.out_vld), 64'd0);

        // Steady state: two in, two out, across several pointer wraps
        drive(1'b1, 14'h0040, 2'b11, {tag_of(14'h0040), tag_of(14'h0041)}, 2'd0);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 14'(14'h0042 + 2*i), 2'b11,
                  {tag_of(14'(14'h0042 + 2*i)), tag_of(14'(14'h0043 + 2*i))}, 2'd2);
            step();
            chk("ss_vld", 64'(bus.out_vld), 64'd3);
            chk("ss_pc0", 64'(bus.out_pc0), 64'(14'h0042 + 2*i));
            chk("ss_i1", 64'(bus.out_instr1), 64'(tag_of(14'(14'h0043 + 2*i))));
        end
        chk("ss_rdy", 64'(bus.in_rdy), 64'd1);
        drive(1'b0, 14'h0, 2'b00, 64'h0, 2'd2);
        step();
        chk("ss_empty", 64'(bus.out_vld), 64'd0);

        // Flush with simultaneous enqueue and dequeue
        drive(1'b1, 14'h0080, 2'b11, 64'h80808080_81818181, 2'd0);
        step();
        drive(1'b1, 14'h0082, 2'b11, 64'h82828282_83838383, 2'd0);
        step();
        drive(1'b1, 14'h0084, 2'b01, 64'h84848484_85858585, 2'd0);
        step();
        chk("pre_fl_rdy", 64'(bus.in_rdy), 64'd1);
        bus.flush = 1'b1;
        drive(1'b1, 14'h0090, 2'b11, 64'h90909090_91919191, 2'd1);
        step();
        bus.flush = 1'b0;
        chk("fl_vld", 64'(bus.out_vld), 64'd0);
        chk("fl_rdy", 64'(bus.in_rdy), 64'd1);
        chk("fl_err", 64'(bus.err), 64'd1);
        drive(1'b1, 14'h00A0, 2'b11, 64'hA0A0A0A0_A1A1A1A1, 2'd0);
        step();
        chk("post_fl_vld", 64'(bus.out_vld), 64'd3);
        chk("post_fl_pc0", 64'(bus.out_pc0), 64'h00A0);
        chk("post_fl_i0", 64'(bus.out_instr0), 64'hA0A0A0A0);

        // Underflow: dequeue two with one held
        drive(1'b0, 14'h0, 2'b00, 64'h0, 2'd1);
        step();
        drive(1'b0, 14'h0, 2'b00, 64'h0, 2'd2);
        step();
        chk("unf_err", 64'(bus.err), 64'd3);
        chk("unf_vld", 64'(bus.out_vld), 64'd1);
        chk("unf_pc0", 64'(bus.out_pc0), 64'h00A1);

        // Reset mid-stream overrides everything
        rstn = 1'b0;
        bus.flush = 1'b1;
        drive(1'b1, 14'h00B0, 2'b11, 64'hB0B0B0B0_B1B1B1B1, 2'd1);
        step();
        chk("rst2_vld", 64'(bus.out_vld), 64'd0);
        chk("rst2_err", 64'(bus.err), 64'd0);
        chk("rst2_rdy", 64'(bus.in_rdy), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
